// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_pkg
// Description : Shared constants and state encoding for the "0110" serial
//               pattern link (transmitter and receiver sides).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_tx_pkg;

    // Frame phases of the transmitter, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Default sync header, sent MSB first.
    localparam int              c_sync_w = 4;
    localparam logic [c_sync_w-1:0] c_sync = 4'b0110;

    // Largest of three phase lengths.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Phase counter width; at least one bit so the counter always exists.
    function automatic int cnt_width(input int a, input int b, input int c);
        int w;
        w = $clog2(max3(a, b, c));
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_frame_tx_piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : Parallel-in serial-out shift register. Load captures a word,
//               shift moves it one place towards the MSB; the MSB is the
//               serial output.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_shifted;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shifted = 1'b0;
        end else begin : g_wn
            assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
        end
    endgenerate

    // Load has priority over shift; the two never coincide in the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_shifted;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_tx
// Description : Serial frame transmitter. Accepts a payload on load/ready and
//               sends sync header, payload MSB-first, then idle-high gap bits,
//               one bit per clock on a registered serial line.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = c_sync_w,
    parameter logic [SYNC_W-1:0] SYNC     = SYNC_W'(c_sync),
    parameter int                GAP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              sof,
    output logic              eof
);

    localparam int CNT_W    = cnt_width(SYNC_W, DATA_W, GAP_BITS);
    localparam int SYNC_PAD = 1 << CNT_W;

    localparam logic [CNT_W-1:0] c_sync_last = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // State and counter always describe the bit currently on x, so the
    // registered outputs are computed from the next state/count.
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;

    logic             w_accept;
    logic             w_shift;
    logic             w_msb;
    logic [SYNC_PAD-1:0] w_sync_rev;

    // Sync header reordered so the counter indexes it directly; padding is
    // unreachable because the sync counter stops at SYNC_W-1.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_PAD; gi++) begin : g_sync_rev
            if (gi < SYNC_W) begin : g_bit
                assign w_sync_rev[gi] = SYNC[SYNC_W-1-gi];
            end else begin : g_pad
                assign w_sync_rev[gi] = 1'b1;
            end
        end
    endgenerate

    assign ready    = (state_q == ST_IDLE) ||
                      ((state_q == ST_GAP) && (cnt_q == c_gap_last));
    assign w_accept = load && ready;
    assign busy     = (state_q != ST_IDLE);

    // Payload register: captured on accept, advanced once per data bit sent.
    piso_shift #(
        .WIDTH (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_accept),
        .data_i  (data_in),
        .shift_i (w_shift),
        .msb_o   (w_msb)
    );

    // State, phase counter and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b1;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    // Next state/count, then the line value for the bit about to be driven.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = 1'b1;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        w_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q == c_sync_last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_DATA: begin
                if (cnt_q == c_data_last) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            ST_GAP: begin
                if (cnt_q == c_gap_last) begin
                    // A load on the last gap bit chains straight into sync.
                    state_d = load ? ST_SYNC : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            ST_SYNC: begin
                x_d   = w_sync_rev[cnt_d];
                sof_d = (cnt_d == '0);
            end
            ST_DATA: begin
                // Present MSB goes on the line; the register then moves on.
                x_d     = w_msb;
                eof_d   = (cnt_d == c_data_last);
                w_shift = 1'b1;
            end
            default: begin
                x_d = 1'b1;
            end
        endcase
    end

    assign x   = x_q;
    assign sof = sof_q;
    assign eof = eof_q;

endmodule
`default_nettype wire

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter: the sending end of the "0110" serial pattern link.
- Accepts a parallel payload word through a valid/ready handshake and drives one bit per clock on a single serial line: the SYNC_W-bit sync header (default 0110), then the payload MSB-first, then idle-high gap bits.
- Sits upstream of the 0110 Mealy detector; that detector frames each transmission from the sync header.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- SYNC_W, 4, sync header width in bits (>=1).
- SYNC, 4'b0110, sync header, sent MSB first.
- GAP_BITS, 1, idle '1' bits driven after each payload (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- data_in  input  DATA_W  payload; sampled only on an accepted load.
- load  input  1  payload valid.
- ready  output  1  block can accept a load this cycle.
- x  output  1  serial line; registered; idles at 1.
- busy  output  1  frame in progress (any state other than IDLE).
- sof  output  1  high for the cycle x carries the first sync bit.
- eof  output  1  high for the cycle x carries the last payload bit.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, x=1, sof=0, eof=0, shift register and counter cleared. ready=1 and busy=0 from the first cycle after reset.
- Reset mid-frame: the frame is abandoned with no partial completion. The next cycle shows x=1 and the block is in IDLE.
- Handshake: a load is accepted when load && ready at a rising edge. When load=1 and ready=0, load is ignored and data_in is not captured. There is no queueing.
- ready = (state==IDLE) || (state==GAP && gap count on its final bit). ready is combinational from registered state only and never depends on load.
- FSM states:
  - IDLE: x=1. On accept, go to SYNC and capture data_in.
  - SYNC: x=SYNC[SYNC_W-1-i] for i=0..SYNC_W-1. After SYNC_W cycles go to DATA.
  - DATA: x=payload[DATA_W-1-j] for j=0..DATA_W-1, MSB first. After DATA_W cycles go to GAP.
  - GAP: x=1 for GAP_BITS cycles, then go to IDLE. If a load is accepted on the final gap cycle, go directly to SYNC.
- Latency: load accepted at edge t gives the first sync bit on x during cycle t+1, with sof=1 in that cycle.
- Frame length is SYNC_W+DATA_W+GAP_BITS cycles. With back-to-back loads the period is exactly that (13 cycles at defaults), with no extra idle bit.
- sof and eof are registered and aligned with the x bit they tag. Each is high for exactly one cycle per frame.
- Counter width is clog2(max(SYNC_W,DATA_W,GAP_BITS)). It resets to 0 on each state entry and never wraps within a state.
- No bit stuffing. A payload containing the sync pattern will also trigger the downstream detector. Exclusion of such payloads is a system-level responsibility.
- The payload register changes only on an accepted load. data_in changes mid-frame do not affect x.

Decomposition:
- Shared package seq_tx_pkg:
  - state encoding localparams IDLE, SYNC, DATA, GAP (2-bit);
  - default SYNC value and SYNC_W.
- The receiver side uses the same package constants.
- One natural sub-module: piso_shift, a parameterised parallel-in serial-out shift register with load, shift enable and MSB output. It is used for the payload; the sync header is indexed directly from the counter.

Test Plan:
- Reset: drive rst=1 for 2 cycles with load=1 → x=1, ready=1, busy=0, sof=0, eof=0 on release, and no frame starts.
- Single frame: load data_in=8'hA5 → x = 0,1,1,0, 1,0,1,0,0,1,0,1, 1 over cycles t+1..t+13. sof at t+1, eof at t+12, ready high again at t+13.
- Back-to-back: load 8'hFF, then hold load=1 with 8'h00 → the second sof occurs exactly 13 cycles after the first, and x between frames is a single 1.
- Load while busy: pulse load with 8'h3C during the DATA state of an 8'hA5 frame → the A5 bits are unchanged, no second frame is sent, and busy drops after the gap.
- Reset mid-frame: assert rst during the 3rd payload bit → x=1 and busy=0 on the next cycle, and eof never fires.
- Loopback with the 0110 detector: send 8'hFF → z pulses once, in the cycle of the 4th sync bit. Send 8'h36 → z pulses twice (sync plus in-payload 0110), confirming the documented no-stuffing behaviour.
